// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encodings, special
// scancodes and the set-2 scancode to ASCII table.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    NORMAL,
    BREAK,
    EXT,
    EXT_BREAK
  } dec_state_t;

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } lookup_t;

  // Letters follow shift; digits and control keys ignore it.
  function automatic lookup_t scan_to_ascii(input logic [7:0] code, input logic shift);
    lookup_t    r;
    logic [7:0] letter;
    // NOTE: every variable gets a default first, so no path leaves it unassigned.
    r      = '0;
    letter = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00) begin
      r.valid = 1'b1;
      r.ascii = shift ? (letter - 8'h20) : letter;
    end else begin
      r.valid = 1'b1;
      case (code)
        8'h45: r.ascii = 8'h30; 8'h16: r.ascii = 8'h31; 8'h1E: r.ascii = 8'h32;
        8'h26: r.ascii = 8'h33; 8'h25: r.ascii = 8'h34; 8'h2E: r.ascii = 8'h35;
        8'h36: r.ascii = 8'h36; 8'h3D: r.ascii = 8'h37; 8'h3E: r.ascii = 8'h38;
        8'h46: r.ascii = 8'h39;
        8'h29: r.ascii = 8'h20;
        8'h5A: r.ascii = 8'h0D;
        8'h66: r.ascii = 8'h08;
        8'h0D: r.ascii = 8'h09;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and de-glitches the keyboard lines and
// delivers each good 11-bit frame's scancode as a one-cycle strobe.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_level;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;

  // A new clock level is accepted only after FILTER_LEN consecutive samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_level <= 1'b1;
      filt_cnt   <= '0;
      fall       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading last cycle's values.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] != filt_level) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_level <= clk_sync[1];
          filt_cnt   <= '0;
          fall       <= filt_level;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            shreg   <= '0;
            if (!data_sync[1]) state <= DATA;
            else               frame_err <= 1'b1;
          end
          DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_sync[1];
            state      <= STOP;
          end
          STOP: begin
            if (data_sync[1] && (^{shreg, parity_bit})) begin
              code       <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled keyboard must not wedge the receiver mid-frame.
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          tmo_cnt   <= '0;
          bit_cnt   <= '0;
          shreg     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_ascii_dec.sv
// PS/2 keyboard to ASCII decoder: tracks make/break/extended prefixes and the
// shift keys, and emits one write strobe per printable key press.
module ps2_ascii_dec
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_ascii,
  output logic       ps2_write,
  output logic       frame_err,
  output logic       shift_active
);

  logic [7:0] code;
  logic       code_valid;
  dec_state_t dec_state;
  logic       lshift;
  logic       rshift;
  lookup_t    lk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  assign shift_active = lshift | rshift;
  assign lk           = scan_to_ascii(code, shift_active);

  // Only good frames reach the decoder, so a frame error never disturbs its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state <= NORMAL;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      ps2_ascii <= 8'h00;
      ps2_write <= 1'b0;
    end else begin
      ps2_write <= 1'b0;
      if (code_valid) begin
        case (dec_state)
          NORMAL: begin
            if (code == CODE_BREAK)       dec_state <= BREAK;
            else if (code == CODE_EXT)    dec_state <= EXT;
            else if (code == CODE_LSHIFT) lshift <= 1'b1;
            else if (code == CODE_RSHIFT) rshift <= 1'b1;
            else if (lk.valid) begin
              ps2_ascii <= lk.ascii;
              ps2_write <= 1'b1;
            end
          end
          BREAK: begin
            if (code == CODE_LSHIFT) lshift <= 1'b0;
            if (code == CODE_RSHIFT) rshift <= 1'b0;
            dec_state <= NORMAL;
          end
          EXT: begin
            if (code == CODE_BREAK) dec_state <= EXT_BREAK;
            else                    dec_state <= NORMAL;
          end
          EXT_BREAK: dec_state <= NORMAL;
          default:   dec_state <= NORMAL;
        endcase
      end
    end
  end

endmodule
